// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP issue/reorder front end.
//   mode_e       : retired operation class (mul/add/sub/div/illegal)
//   OP_FP/FUNC_* : instruction encodings recognised by the decoder
//   FLAG_*       : bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag word
//   rob_entry_t  : one reorder-buffer slot
//   fpu_decode   : opcode/func_code -> mode_e, never X
package fpu_pkg;

    typedef enum logic [2:0] {
        MUL = 3'b000,
        ADD = 3'b001,
        SUB = 3'b010,
        DIV = 3'b011,
        ILL = 3'b111
    } mode_e;

    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] FUNC_ADD  = 7'b0000000;
    localparam logic [6:0] FUNC_SUB  = 7'b0000100;
    localparam logic [6:0] FUNC_MUL  = 7'b0001000;
    localparam logic [6:0] FUNC_DIV  = 7'b0001100;

    localparam int FLAGS_W = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Flags reported for an illegal instruction: invalid-operation only.
    localparam logic [FLAGS_W-1:0] ILL_FLAGS = FLAGS_W'(1) << FLAG_NV;

    // Result storage is sized for the widest supported datapath; narrower
    // builds zero-extend on write and truncate on read.
    localparam int FPU_MAX_W = 64;

    typedef struct packed {
        logic                  done;
        mode_e                 mode;
        logic [FPU_MAX_W-1:0]  result;
        logic [FLAGS_W-1:0]    flags;
    } rob_entry_t;

    function automatic mode_e fpu_decode(input logic [6:0] op_code,
                                         input logic [6:0] func_code);
        mode_e m;
        m = ILL;
        if (op_code == OP_FP) begin
            case (func_code)
                FUNC_ADD: m = ADD;
                FUNC_SUB: m = SUB;
                FUNC_MUL: m = MUL;
                FUNC_DIV: m = DIV;
                default:  m = ILL;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// fpu_tag_pipe: LAT-deep shift pipe carrying {valid, ROB tag} alongside a
// fixed-latency pipelined execution unit, so the result that appears LAT
// cycles after a start pulse can be steered to its ROB slot.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (clears valids)
//   in_vld, in_tag    start pulse and ROB tag of the issued op
//   out_vld, out_tag  tag of the unit result present this cycle
module fpu_tag_pipe #(
    parameter int LAT   = 1,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag
);

    logic [LAT-1:0]   vld_p;
    logic [TAG_W-1:0] tag_p [LAT];

    // Stage 0 captures the issue; stage LAT-1 lines up with the unit output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= in_tag;
        for (int i = 1; i < LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

    assign out_vld = vld_p[LAT-1];
    assign out_tag = tag_p[LAT-1];

endmodule

// File: rtl/fpu_issue_rob.sv
// fpu_issue_rob: FP instruction issue stage with an in-order reorder buffer.
// Decodes FP instructions, starts the external mul / add-sub / div units and
// retires results strictly in issue order with their IEEE flags.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready             instruction handshake
//   in_op_code, in_func_code      instruction encoding
//   in_a, in_b                    operands, forwarded as unit_a/unit_b
//   mul_start, add_start, add_sub, div_start   unit issue pulses
//   mul_/add_/div_result, _flags  unit outputs; div_done marks div output
//   out_valid/out_ready           retire handshake
//   out_result, out_flags, out_mode            retired op
// Optional: define FPU_ROB_PERF_EN to add perf_retired, perf_issue_stall and
// perf_out_stall saturating 32-bit counters.
module fpu_issue_rob
    import fpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_op_code,
    input  logic [6:0]         in_func_code,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   unit_a,
    output logic [WIDTH-1:0]   unit_b,
    output logic               mul_start,
    output logic               add_start,
    output logic               add_sub,
    output logic               div_start,
    input  logic [WIDTH-1:0]   mul_result,
    input  logic [WIDTH-1:0]   add_result,
    input  logic [WIDTH-1:0]   div_result,
    input  logic [FLAGS_W-1:0] mul_flags,
    input  logic [FLAGS_W-1:0] add_flags,
    input  logic [FLAGS_W-1:0] div_flags,
    input  logic               div_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [2:0]         out_mode
`ifdef FPU_ROB_PERF_EN
    ,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_issue_stall,
    output logic [31:0]        perf_out_stall
`endif
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    rob_entry_t       rob [DEPTH];
    rob_entry_t       head_ent;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             div_pending;
    logic [TAG_W-1:0] div_tag;
    mode_e            dec_mode;
    logic             accept;
    logic             retire;
    logic             mul_wb_vld;
    logic [TAG_W-1:0] mul_wb_tag;
    logic             add_wb_vld;
    logic [TAG_W-1:0] add_wb_tag;
    logic             div_wb;
    logic             unused_res_bits;

    // Issue: decode and handshake
    assign dec_mode = fpu_decode(in_op_code, in_func_code);

    // Only registered state feeds in_ready; a same-cycle retire does not
    // open a slot, which keeps out_ready off the in_ready path.
    assign in_ready = rst && (count < FULL_CNT) && !((dec_mode == DIV) && div_pending);
    assign accept   = in_valid && in_ready;

    assign mul_start = accept && (dec_mode == MUL);
    assign add_start = accept && ((dec_mode == ADD) || (dec_mode == SUB));
    assign add_sub   = (dec_mode == SUB);
    assign div_start = accept && (dec_mode == DIV);
    assign unit_a    = in_a;
    assign unit_b    = in_b;

    // Execution: tag tracking for the fixed-latency units
    fpu_tag_pipe #(.LAT(MUL_LAT), .TAG_W(TAG_W)) u_mul_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (mul_start),
        .in_tag  (tail),
        .out_vld (mul_wb_vld),
        .out_tag (mul_wb_tag)
    );

    fpu_tag_pipe #(.LAT(ADD_LAT), .TAG_W(TAG_W)) u_add_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (add_start),
        .in_tag  (tail),
        .out_vld (add_wb_vld),
        .out_tag (add_wb_tag)
    );

    // A div_done with nothing outstanding (e.g. left over from before a
    // reset) is dropped.
    assign div_wb = div_done && div_pending;

    // Retire
    assign head_ent   = rob[head];
    assign out_valid  = (count != '0) && head_ent.done;
    assign retire     = out_valid && out_ready;
    assign out_result = out_valid ? head_ent.result[WIDTH-1:0] : '0;
    assign out_flags  = out_valid ? head_ent.flags : '0;
    assign out_mode   = out_valid ? head_ent.mode : ILL;

    assign unused_res_bits = ^head_ent.result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            div_pending <= 1'b0;
            div_tag     <= '0;
        end else begin
            if (accept) begin
                tail <= tail + 1'b1;
            end
            if (retire) begin
                head <= head + 1'b1;
            end
            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (div_start) begin
                div_pending <= 1'b1;
                div_tag     <= tail;
            end else if (div_wb) begin
                div_pending <= 1'b0;
            end
        end
    end

    // ROB storage: only the done bits are reset. Retire clears head, accept
    // fills tail and up to three unit write-backs land in other slots; none
    // of these can target the same entry in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob[i].done <= 1'b0;
            end
        end else begin
            if (retire) begin
                rob[head].done <= 1'b0;
            end
            if (accept) begin
                rob[tail].done   <= (dec_mode == ILL);
                rob[tail].mode   <= dec_mode;
                rob[tail].result <= '0;
                rob[tail].flags  <= (dec_mode == ILL) ? ILL_FLAGS : '0;
            end
            if (mul_wb_vld) begin
                rob[mul_wb_tag].done   <= 1'b1;
                rob[mul_wb_tag].result <= FPU_MAX_W'(mul_result);
                rob[mul_wb_tag].flags  <= mul_flags;
            end
            if (add_wb_vld) begin
                rob[add_wb_tag].done   <= 1'b1;
                rob[add_wb_tag].result <= FPU_MAX_W'(add_result);
                rob[add_wb_tag].flags  <= add_flags;
            end
            if (div_wb) begin
                rob[div_tag].done   <= 1'b1;
                rob[div_tag].result <= FPU_MAX_W'(div_result);
                rob[div_tag].flags  <= div_flags;
            end
        end
    end

`ifdef FPU_ROB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired     <= '0;
            perf_issue_stall <= '0;
            perf_out_stall   <= '0;
        end else begin
            if (retire) begin
                perf_retired <= sat_inc(perf_retired);
            end
            if (in_valid && !in_ready) begin
                perf_issue_stall <= sat_inc(perf_issue_stall);
            end
            if (out_valid && !out_ready) begin
                perf_out_stall <= sat_inc(perf_out_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_rob.sv
// tb_fpu_issue_rob: directed self-checking bench for fpu_issue_rob with
// behavioural mul/add/div unit models and an in-order result scoreboard.
module tb_fpu_issue_rob;
    import fpu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 3;
    localparam int ADD_LAT = 2;
    localparam int DIV_LAT = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_op_code;
    logic [6:0]       in_func_code;
    logic [WIDTH-1:0] in_a, in_b;
    logic [WIDTH-1:0] unit_a, unit_b;
    logic             mul_start, add_start, add_sub, div_start;
    logic [WIDTH-1:0] mul_result, add_result, div_result;
    logic [4:0]       mul_flags, add_flags, div_flags;
    logic             div_done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_flags;
    logic [2:0]       out_mode;

    always #5 clk = ~clk;

    fpu_issue_rob #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code), .in_func_code(in_func_code),
        .in_a(in_a), .in_b(in_b),
        .unit_a(unit_a), .unit_b(unit_b),
        .mul_start(mul_start), .add_start(add_start), .add_sub(add_sub), .div_start(div_start),
        .mul_result(mul_result), .add_result(add_result), .div_result(div_result),
        .mul_flags(mul_flags), .add_flags(add_flags), .div_flags(div_flags),
        .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_mode(out_mode)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [2:0]  mode;
    } exp_t;

    exp_t sb[$];

    // Unit behaviour: arbitrary but deterministic, with the IEEE cases used
    // in the directed steps returning their true results.
    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return sub ? a - b : a + b;
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ b;
    endfunction

    function automatic logic [4:0] f_flags(input logic [31:0] r, input logic [4:0] unit_code);
        return r[4:0] ^ unit_code;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.mode = m;
        case (m)
            MUL:     begin e.res = f_mul(a, b);    e.flags = f_flags(e.res, 5'b00101); end
            ADD:     begin e.res = f_add(a, b, 0); e.flags = f_flags(e.res, 5'b00000); end
            SUB:     begin e.res = f_add(a, b, 1); e.flags = f_flags(e.res, 5'b00000); end
            DIV:     begin e.res = f_div(a, b);    e.flags = f_flags(e.res, 5'b01010); end
            default: begin e.res = '0;             e.flags = 5'b10000; end
        endcase
        return e;
    endfunction

    // Pipelined mul and add models, result present MUL_LAT/ADD_LAT cycles
    // after the start cycle; idle cycles carry a junk pattern.
    logic [31:0] mres_p [MUL_LAT];
    logic [4:0]  mflg_p [MUL_LAT];
    logic [31:0] ares_p [ADD_LAT];
    logic [4:0]  aflg_p [ADD_LAT];

    always @(posedge clk) begin
        mres_p[0] <= mul_start ? f_mul(unit_a, unit_b) : 32'hDEAD_BEEF;
        mflg_p[0] <= mul_start ? f_flags(f_mul(unit_a, unit_b), 5'b00101) : 5'b11111;
        for (int i = 1; i < MUL_LAT; i++) begin
            mres_p[i] <= mres_p[i-1];
            mflg_p[i] <= mflg_p[i-1];
        end
        ares_p[0] <= add_start ? f_add(unit_a, unit_b, add_sub) : 32'hDEAD_BEEF;
        aflg_p[0] <= add_start ? f_flags(f_add(unit_a, unit_b, add_sub), 5'b00000) : 5'b11111;
        for (int i = 1; i < ADD_LAT; i++) begin
            ares_p[i] <= ares_p[i-1];
            aflg_p[i] <= aflg_p[i-1];
        end
    end

    assign mul_result = mres_p[MUL_LAT-1];
    assign mul_flags  = mflg_p[MUL_LAT-1];
    assign add_result = ares_p[ADD_LAT-1];
    assign add_flags  = aflg_p[ADD_LAT-1];

    // Non-pipelined div model; it is deliberately not reset so a division
    // in flight across a DUT reset still produces its (stale) div_done.
    int          div_cnt = 0;
    logic [31:0] div_hold;

    initial begin
        div_done   = 1'b0;
        div_result = 32'hDEAD_BEEF;
        div_flags  = 5'b11111;
    end

    always @(posedge clk) begin
        div_done   <= 1'b0;
        div_result <= 32'hDEAD_BEEF;
        div_flags  <= 5'b11111;
        if (div_start) begin
            div_cnt  <= DIV_LAT;
            div_hold <= f_div(unit_a, unit_b);
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_done   <= 1'b1;
                div_result <= div_hold;
                div_flags  <= f_flags(div_hold, 5'b01010);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Retire monitor: pops the scoreboard on every handshake and checks that
    // a stalled output stays valid with unchanged data.
    exp_t        ck_e;
    logic        stall_prev = 1'b0;
    logic [39:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_result, out_flags, out_mode}, held);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    ck_e = sb.pop_front();
                    chk("ret_result", out_result, ck_e.res);
                    chk("ret_flags", out_flags, ck_e.flags);
                    chk("ret_mode", out_mode, ck_e.mode);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_result, out_flags, out_mode};
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [6:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] em);
        int n;
        in_valid     = 1'b1;
        in_op_code   = op;
        in_func_code = fn;
        in_a         = a;
        in_b         = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", in_ready, 1);
        if (in_ready) begin
            chk("mul_start", mul_start, em == MUL);
            chk("add_start", add_start, (em == ADD) || (em == SUB));
            chk("div_start", div_start, em == DIV);
            if (em == ADD || em == SUB) chk("add_sub", add_sub, em == SUB);
            if (em != ILL) chk("unit_ops", {unit_a, unit_b}, {a, b});
            sb.push_back(mk_exp(em, a, b));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b1;
        in_op_code   = OP_FP;
        in_func_code = FUNC_MUL;
        in_a         = 32'd3;
        in_b         = 32'd4;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_mode", out_mode, ILL);
        chk("rst_mul_start", mul_start, 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single add: latency and result
        issue(OP_FP, FUNC_ADD, 32'h3F80_0000, 32'h4000_0000, ADD);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("add_latency", n, ADD_LAT);
        @(posedge clk);
        #1;
        drain();

        // Slow div followed by a fast add: add must wait behind the div
        issue(OP_FP, FUNC_DIV, 32'h40C0_0000, 32'h4000_0000, DIV);
        issue(OP_FP, FUNC_ADD, 32'd1, 32'd2, ADD);
        drain();

        // Fill the ROB with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            issue(OP_FP, FUNC_MUL, 32'(i + 3), 32'(i + 5), MUL);
        end
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        repeat (MUL_LAT + 2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("retire_same_cycle_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("retire_next_cycle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Second div held while the first is outstanding; a mul still issues
        issue(OP_FP, FUNC_DIV, 32'h40C0_0000, 32'h4000_0000, DIV);
        in_valid     = 1'b1;
        in_func_code = FUNC_DIV;
        in_a         = 32'd9;
        in_b         = 32'd3;
        @(negedge clk);
        chk("div2_blocked", in_ready, 0);
        chk("div2_no_start", div_start, 0);
        @(posedge clk);
        #1;
        issue(OP_FP, FUNC_MUL, 32'd6, 32'd7, MUL);
        issue(OP_FP, FUNC_DIV, 32'd9, 32'd3, DIV);
        drain();

        // Illegal encodings interleaved with a legal sub
        issue(7'b0110011, FUNC_ADD, 32'd1, 32'd2, ILL);
        issue(OP_FP, FUNC_SUB, 32'd9, 32'd4, SUB);
        issue(OP_FP, 7'b0010000, 32'd3, 32'd4, ILL);
        drain();

        // Reset with three ops in flight and a division outstanding
        out_ready = 1'b0;
        issue(OP_FP, FUNC_MUL, 32'd2, 32'd3, MUL);
        issue(OP_FP, FUNC_DIV, 32'd8, 32'd2, DIV);
        issue(OP_FP, FUNC_ADD, 32'd4, 32'd5, ADD);
        #2;
        rst          = 1'b0;
        in_valid     = 1'b1;
        in_func_code = FUNC_MUL;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_result", out_result, 0);
        chk("mid_rst_out_flags", out_flags, 0);
        chk("mid_rst_out_mode", out_mode, ILL);
        chk("mid_rst_starts", {mul_start, add_start, div_start}, 0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst          = 1'b1;
        in_func_code = FUNC_DIV;
        @(negedge clk);
        chk("post_rst_div_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(OP_FP, FUNC_ADD, 32'd10, 32'd20, ADD);
        drain();
        repeat (DIV_LAT + 5) @(posedge clk);
        #1;
        chk("stale_div_ignored", out_valid, 0);
        chk("sb_final_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
